// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants and decoder FSM state type.
package seg_pkg;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] HEX_PAT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   typedef enum logic [1:0] {IDLE, SETTLE, DWELL} state_t;
endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: active-low 7-segment pattern to hex nibble; blank is set for all-off and for unknown patterns.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       blank,
   output logic       invalid
);
   always_comb begin
      nibble  = '0;
      blank   = 1'b1;
      invalid = (seg != SEG_BLANK);
      for (int k = 0; k < 16; k++)
         if (seg == HEX_PAT[k]) begin
            nibble  = 4'(k);
            blank   = 1'b0;
            invalid = 1'b0;
         end
   end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers hex frames from a scanned active-low seven-segment display bus.
// Defining SEG_ERR_COUNT_EN adds a saturating err_count output.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS-1:0]   ss_digit,
   input  logic [6:0]              segment,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   digit_blank,
   output logic                    frame_valid,
   output logic                    err_seg,
   output logic                    err_anode
`ifdef SEG_ERR_COUNT_EN
   ,
   output logic [7:0]              err_count
`endif
);
   localparam int W = NUM_DIGITS + 7;
   logic [W-1:0]            samp, samp_q;
   logic [3:0]              cnt, cnt_nx;
   state_t                  state;
   logic [NUM_DIGITS-1:0]   anodes, seen, fbuf_blank;
   logic [4*NUM_DIGITS-1:0] fbuf_val;
   logic [3:0]              nib;
   logic                    blank, invalid, chg, lit, ready, multi, do_cap;

   assign anodes = samp[W-1:7];
   assign chg    = samp != samp_q;
   assign lit    = ~&anodes;
   assign multi  = !$onehot(~anodes);
   assign cnt_nx = chg ? 4'd0 : (cnt == 4'(STABLE_CYCLES) ? cnt : cnt + 4'd1);
   // capture fires on the edge where the current sample completes its STABLE_CYCLES-long run
   assign ready  = lit && (chg || state == SETTLE) && cnt_nx == 4'(STABLE_CYCLES - 1);
   assign do_cap = ready && !multi;

   seg_pattern_decode u_dec (
      .seg    (samp[6:0]),
      .nibble (nib),
      .blank  (blank),
      .invalid(invalid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp        <= '0;
         samp_q      <= '0;
         cnt         <= '0;
         state       <= IDLE;
         seen        <= '0;
         fbuf_val    <= '0;
         fbuf_blank  <= '1;
         value       <= '0;
         digit_blank <= '1;
         frame_valid <= 1'b0;
         err_seg     <= 1'b0;
         err_anode   <= 1'b0;
      end else begin
         samp        <= {ss_digit, segment};
         samp_q      <= samp;
         cnt         <= cnt_nx;
         state       <= ready ? DWELL : chg ? (lit ? SETTLE : IDLE) : state;
         err_anode   <= ready && multi;
         err_seg     <= do_cap && invalid;
         frame_valid <= &seen;
         if (&seen) begin
            value       <= fbuf_val;
            digit_blank <= fbuf_blank;
         end
         seen <= (&seen ? '0 : seen) | (do_cap ? ~anodes : '0);
         for (int i = 0; i < NUM_DIGITS; i++)
            if (do_cap && !anodes[i]) begin
               fbuf_val[4*i +: 4] <= nib;
               fbuf_blank[i]      <= blank;
            end
      end
   end

`ifdef SEG_ERR_COUNT_EN
   logic [8:0] err_sum;
   assign err_sum = {1'b0, err_count} + 9'(err_seg) + 9'(err_anode);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_count <= '0;
      else        err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
   end
`endif
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scenarios plus a randomized scan checked against a run-length level model.
module tb_seg_scan_decoder;
   localparam int N = 8;
   localparam int S = 4;
   localparam logic [6:0] HEX [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0] ss_digit = '1;
   logic [6:0] segment = 7'h7F;
   logic [4*N-1:0] value;
   logic [N-1:0] digit_blank;
   logic frame_valid, err_seg, err_anode;
`ifdef SEG_ERR_COUNT_EN
   logic [7:0] err_count;
`endif

   int checks = 0;
   int errors = 0;
   int n_frames = 0, n_seg = 0, n_an = 0;
   logic [4*N-1:0] fr_val[$];
   logic [N-1:0] fr_blank[$];

   always #5 clk = ~clk;

   seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ss_digit   (ss_digit),
      .segment    (segment),
      .value      (value),
      .digit_blank(digit_blank),
      .frame_valid(frame_valid),
      .err_seg    (err_seg),
      .err_anode  (err_anode)
`ifdef SEG_ERR_COUNT_EN
      ,
      .err_count  (err_count)
`endif
   );

   always @(negedge clk) begin
      if (frame_valid) begin
         n_frames++;
         fr_val.push_back(value);
         fr_blank.push_back(digit_blank);
      end
      if (err_seg) n_seg++;
      if (err_anode) n_an++;
   end

   function automatic logic [N-1:0] sel(input int d);
      return ~(N'(1) << d);
   endfunction

   task automatic drive(input logic [N-1:0] an, input logic [6:0] sg, input int n);
      ss_digit = an;
      segment = sg;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      drive('1, 7'h7F, n);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic scan(input logic [4*N-1:0] v, input logic [N-1:0] bl, input int n);
      for (int d = 0; d < N; d++) drive(sel(d), bl[d] ? 7'h7F : HEX[v[4*d +: 4]], n);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(2);
      checks++; if (value !== '0) begin errors++; $display("FAIL reset_value got %h want 0", value); end
      checks++; if (digit_blank !== '1) begin errors++; $display("FAIL reset_blank got %h want ff", digit_blank); end
      checks++; if ({frame_valid, err_seg, err_anode} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {frame_valid, err_seg, err_anode}); end
`ifdef SEG_ERR_COUNT_EN
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
`endif
      rst_n = 1'b1;
      idle(3);
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL post_reset_fv got %b want 0", frame_valid); end
   endtask

   task automatic test_scan_basic();
      int cnt = 0, at = -1;
      do_reset();
      for (int d = 0; d < N; d++) begin
         ss_digit = sel(d);
         segment = (d == 0) ? HEX[9] : HEX[0];
         for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (frame_valid) begin cnt++; at = d * 10 + k; end
         end
      end
      idle(4);
      checks++; if (cnt != 1) begin errors++; $display("FAIL basic_frame_count got %0d want 1", cnt); end
      checks++; if (at != 7 * 10 + S + 2) begin errors++; $display("FAIL basic_frame_time got %0d want %0d", at, 7 * 10 + S + 2); end
      checks++; if (value !== 32'h00000009) begin errors++; $display("FAIL basic_value got %h want 00000009", value); end
      checks++; if (digit_blank !== 8'h00) begin errors++; $display("FAIL basic_blank got %h want 00", digit_blank); end
   endtask

   task automatic test_stable();
      int hit = 0, at = -1, f0;
      do_reset();
      ss_digit = sel(2); segment = 7'h55;
      for (int k = 1; k <= S + 4; k++) begin
         @(negedge clk);
         if (err_seg) hit++;
         if (k == S - 1) begin ss_digit = '1; segment = 7'h7F; end
      end
      checks++; if (hit != 0) begin errors++; $display("FAIL short_hold_captured got %0d want 0", hit); end
      ss_digit = sel(2); segment = 7'h55;
      for (int k = 1; k <= S + 4; k++) begin
         @(negedge clk);
         if (err_seg) begin hit++; at = k; end
         if (k == S) begin ss_digit = '1; segment = 7'h7F; end
      end
      checks++; if (hit != 1 || at != S + 1) begin errors++; $display("FAIL exact_hold_latency got n=%0d at=%0d want n=1 at=%0d", hit, at, S + 1); end
      do_reset();
      f0 = n_frames;
      for (int d = 0; d < N; d++) drive(sel(d), HEX[d], d == 5 ? S - 1 : S + 2);
      idle(S + 3);
      checks++; if (n_frames != f0) begin errors++; $display("FAIL short_digit_frame got %0d want 0", n_frames - f0); end
      drive(sel(5), HEX[5], S);
      idle(S + 3);
      checks++; if (n_frames != f0 + 1) begin errors++; $display("FAIL exact_digit_frame got %0d want 1", n_frames - f0); end
      checks++; if (value !== 32'h76543210 || digit_blank !== 8'h00) begin errors++; $display("FAIL exact_digit_value got %h/%h want 76543210/00", value, digit_blank); end
   endtask

   task automatic test_anode_err();
      int a0, s0, f0;
      do_reset();
      a0 = n_an; s0 = n_seg; f0 = n_frames;
      drive(8'b11111100, HEX[1], 10);
      idle(4);
      checks++; if (n_an - a0 != 1) begin errors++; $display("FAIL anode_err_count got %0d want 1", n_an - a0); end
      checks++; if (n_seg != s0 || n_frames != f0) begin errors++; $display("FAIL anode_side_effects got seg=%0d fr=%0d want 0/0", n_seg - s0, n_frames - f0); end
   endtask

   task automatic test_seg_err();
      int s0, f0;
      logic [31:0] v = 32'hFEDCBA98;
      do_reset();
      s0 = n_seg; f0 = n_frames;
      for (int d = 0; d < N; d++) drive(sel(d), d == 3 ? 7'h55 : HEX[v[4*d +: 4]], 8);
      idle(4);
      checks++; if (n_seg - s0 != 1) begin errors++; $display("FAIL seg_err_count got %0d want 1", n_seg - s0); end
      checks++; if (n_frames - f0 != 1) begin errors++; $display("FAIL seg_err_frames got %0d want 1", n_frames - f0); end
      checks++; if (value !== 32'hFEDC0A98 || digit_blank !== 8'h08) begin errors++; $display("FAIL seg_err_frame got %h/%h want fedc0a98/08", value, digit_blank); end
   endtask

   task automatic test_reset_mid();
      int f0;
      do_reset();
      scan(32'h12345678, 8'h00, 8);
      idle(3);
      for (int d = 0; d < 5; d++) drive(sel(d), HEX[d + 1], 8);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (value !== '0 || digit_blank !== '1 || frame_valid !== 1'b0) begin errors++; $display("FAIL async_reset got %h/%h/%b want 0/ff/0", value, digit_blank, frame_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      f0 = n_frames;
      for (int d = 5; d < N; d++) drive(sel(d), 7'h7F, 8);
      idle(6);
      checks++; if (n_frames != f0) begin errors++; $display("FAIL partial_discard got %0d want 0", n_frames - f0); end
      scan(32'h00000639, 8'hF8, 8);
      idle(6);
      checks++; if (n_frames - f0 != 1) begin errors++; $display("FAIL sum_frames got %0d want 1", n_frames - f0); end
      checks++; if (value !== 32'h00000639 || digit_blank !== 8'hF8) begin errors++; $display("FAIL sum_frame got %h/%h want 00000639/f8", value, digit_blank); end
   endtask

   task automatic test_random();
      logic [4*N-1:0] m_val = '0, ev[$];
      logic [N-1:0] m_blank = '1, m_seen = '0, eb[$];
      logic [N+6:0] cur = {{N{1'b1}}, 7'h7F}, pat;
      int cur_len = 0, e_seg = 0, e_an = 0, fq0, s0, a0, n;
      bit done = 1;
      do_reset();
      fq0 = fr_val.size(); s0 = n_seg; a0 = n_an;
      for (int h = 0; h < 400; h++) begin
         int r = $urandom_range(0, 9), a = $urandom_range(0, N - 1), b = $urandom_range(0, N - 1);
         int q = $urandom_range(0, 9);
         pat[N+6:7] = r < 8 ? sel(a) : (r == 8 && a != b) ? (sel(a) & sel(b)) : '1;
         pat[6:0] = q < 7 ? HEX[$urandom_range(0, 15)] : q == 7 ? 7'h7F : 7'($urandom);
         n = $urandom_range(1, 2 * S);
         drive(pat[N+6:7], pat[6:0], n);
         if (pat == cur) cur_len += n;
         else begin cur = pat; cur_len = n; done = 0; end
         if (!done && cur_len >= S && cur[N+6:7] != '1) begin
            done = 1;
            if ($countones(~cur[N+6:7]) > 1) e_an++;
            else begin
               int idx = 0, nib = 0;
               bit found = 0;
               for (int d = 0; d < N; d++) if (!cur[7 + d]) idx = d;
               for (int k = 0; k < 16; k++) if (cur[6:0] == HEX[k]) begin found = 1; nib = k; end
               if (!found && cur[6:0] != 7'h7F) e_seg++;
               m_val[4*idx +: 4] = 4'(nib);
               m_blank[idx] = !found;
               m_seen[idx] = 1'b1;
               if (&m_seen) begin ev.push_back(m_val); eb.push_back(m_blank); m_seen = '0; end
            end
         end
      end
      idle(S + 6);
      checks++; if (fr_val.size() - fq0 != ev.size()) begin errors++; $display("FAIL rand_frames got %0d want %0d", fr_val.size() - fq0, ev.size()); end
      for (int i = 0; i < ev.size() && fq0 + i < fr_val.size(); i++) begin
         checks++;
         if (fr_val[fq0 + i] !== ev[i] || fr_blank[fq0 + i] !== eb[i]) begin errors++; $display("FAIL rand_frame%0d got %h/%h want %h/%h", i, fr_val[fq0 + i], fr_blank[fq0 + i], ev[i], eb[i]); end
      end
      checks++; if (n_seg - s0 != e_seg) begin errors++; $display("FAIL rand_err_seg got %0d want %0d", n_seg - s0, e_seg); end
      checks++; if (n_an - a0 != e_an) begin errors++; $display("FAIL rand_err_anode got %0d want %0d", n_an - a0, e_an); end
   endtask

`ifdef SEG_ERR_COUNT_EN
   task automatic test_err_count();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         drive(sel(i % N), 7'h55, S);
         idle(1);
         if (i == 99) begin
            idle(2);
            checks++; if (err_count !== 8'd100) begin errors++; $display("FAIL err_count_100 got %0d want 100", err_count); end
         end
      end
      idle(4);
      checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_count_sat got %0d want 255", err_count); end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_scan_basic();
      test_stable();
      test_anode_err();
      test_seg_err();
      test_reset_mid();
      test_random();
`ifdef SEG_ERR_COUNT_EN
      test_err_count();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
